baud_tick_ctrl: RTL and testbench

Controller that owns the UART baud tick generator. It sequences start/stop of the oversample tick and derives the bit tick from it. It also accepts runtime divisor reconfiguration through a valid/ready handshake. New divisors take effect only on a bit boundary or while stopped, so no partial bit is ever distorted. It sits between the host/ALU configuration interface and the UART RX/TX engines, which consume s_tick and bit_tick.

---
 rtl/baud_tick_ctrl.sv | 112 +++++++++++
 tb/tb_baud_tick_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_ctrl.sv
// UART baud tick controller: start/stop sequencing of the oversample tick, bit tick
// derivation, and divisor reconfiguration that only lands on a bit boundary or while stopped.
module baud_tick_ctrl #(
    parameter int N           = 16,
    parameter int DEFAULT_DIV = 326,
    parameter int OS          = 16,
    parameter int OS_W        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] cfg_div,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         s_tick,
    output logic         bit_tick,
    output logic         busy,
    output logic         pending,
    output logic [N-1:0] div_cur
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [N-1:0]    DIV_RESET = N'(DEFAULT_DIV);
    localparam logic [N-1:0]    MIN_DIV   = N'(2);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS - 1);

    state_t          state_reg;
    logic [N-1:0]    div_reg;
    logic [N-1:0]    pend_reg;
    logic [N-1:0]    cnt_reg;
    logic [OS_W-1:0] os_cnt_reg;
    logic            cfg_err_reg;

    logic            active;
    logic            xfer;
    logic            legal;
    logic [N-1:0]    cnt_next;
    logic [OS_W-1:0] os_cnt_next;

    assign active    = (state_reg != IDLE);
    assign s_tick    = active && (cnt_reg == div_reg - N'(1));
    assign bit_tick  = s_tick && (os_cnt_reg == OS_LAST);
    assign cfg_ready = (state_reg != PENDING);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= MIN_DIV);

    // Free-running advance of both counters while ticking.
    assign cnt_next    = s_tick ? '0 : cnt_reg + N'(1);
    assign os_cnt_next = s_tick ? ((os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_W'(1))
                                : os_cnt_reg;

    assign cfg_err = cfg_err_reg;
    assign busy    = active;
    assign pending = (state_reg == PENDING);
    assign div_cur = div_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            div_reg     <= DIV_RESET;
            pend_reg    <= '0;
            cnt_reg     <= '0;
            os_cnt_reg  <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= xfer && !legal;
            case (state_reg)
                IDLE: begin
                    cnt_reg    <= '0;
                    os_cnt_reg <= '0;
                    if (xfer && legal) div_reg <= cfg_div;
                    if (en) state_reg <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        // Stopping: a new divisor can be applied directly, no bit is in flight.
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                        os_cnt_reg <= '0;
                        if (xfer && legal) div_reg <= cfg_div;
                    end else begin
                        cnt_reg    <= cnt_next;
                        os_cnt_reg <= os_cnt_next;
                        if (xfer && legal) begin
                            pend_reg  <= cfg_div;
                            state_reg <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!en || bit_tick) begin
                        div_reg    <= pend_reg;
                        cnt_reg    <= '0;
                        os_cnt_reg <= '0;
                        state_reg  <= en ? RUN : IDLE;
                    end else begin
                        cnt_reg    <= cnt_next;
                        os_cnt_reg <= os_cnt_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Self-checking bench for baud_tick_ctrl: elapsed-time model compared every cycle,
// plus directed literal expectations for tick positions and handshake behaviour.
module tb_baud_tick_ctrl;

    localparam int N   = 16;
    localparam int DEF = 4;
    localparam int OS  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [N-1:0] cfg_div;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_err;
    logic         s_tick;
    logic         bit_tick;
    logic         busy;
    logic         pending;
    logic [N-1:0] div_cur;

    baud_tick_ctrl #(
        .N(N), .DEFAULT_DIV(DEF), .OS(OS), .OS_W(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .s_tick(s_tick), .bit_tick(bit_tick),
        .busy(busy), .pending(pending), .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time elapsed since the counters last restarted decides every tick.
    int m_div  = DEF;
    int m_pend = 0;
    int m_t    = 0;
    bit m_busy = 1'b0;
    bit m_pf   = 1'b0;
    bit m_err  = 1'b0;
    bit m_s, m_b, m_ok, m_bad;

    always_comb begin
        m_s   = 1'b0;
        m_b   = 1'b0;
        m_ok  = 1'b0;
        m_bad = 1'b0;
        if (m_busy && m_div > 0) begin
            m_s = ((m_t + 1) % m_div) == 0;
            m_b = ((m_t + 1) % (m_div * OS)) == 0;
        end
        m_ok  = cfg_valid && !m_pf && (int'(cfg_div) >= 2);
        m_bad = cfg_valid && !m_pf && (int'(cfg_div) < 2);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_div  <= DEF;
            m_pend <= 0;
            m_t    <= 0;
            m_busy <= 1'b0;
            m_pf   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_err <= m_bad;
            if (!m_busy) begin
                if (m_ok) m_div <= int'(cfg_div);
                if (en) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                end
            end else if (!en) begin
                m_busy <= 1'b0;
                m_t    <= 0;
                m_pf   <= 1'b0;
                if (m_pf) m_div <= m_pend;
                else if (m_ok) m_div <= int'(cfg_div);
            end else if (m_pf && m_b) begin
                m_div <= m_pend;
                m_pf  <= 1'b0;
                m_t   <= 0;
            end else begin
                m_t <= m_t + 1;
                if (m_ok) begin
                    m_pend <= int'(cfg_div);
                    m_pf   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("s_tick", s_tick, m_s);
            check("bit_tick", bit_tick, m_b);
            check("cfg_ready", cfg_ready, !m_pf);
            check("cfg_err", cfg_err, m_err);
            check("busy", busy, m_busy);
            check("pending", pending, m_pf);
            check("div_cur", int'(div_cur), m_div);
            if (cfg_valid && cfg_ready && !reset)
                $display("cfg transfer div=%0d en=%0b busy=%0b", cfg_div, en, busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int first_s, second_s, first_b;

    initial begin
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step(); step();
        cmp_en = 1'b1;
        check("rst_div_cur", int'(div_cur), DEF);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_s_tick", s_tick, 0);
        reset = 1'b0;
        step();

        // Default divisor run, then a divisor change deferred to the bit boundary.
        en = 1'b1; cfg_div = 16'd6;
        step();
        first_s = -1; first_b = -1;
        for (int rc = 0; rc < 80; rc++) begin
            cfg_valid = (rc == 20);
            if (s_tick && first_s < 0) first_s = rc;
            if (bit_tick && first_b < 0) first_b = rc;
            if (rc == 21) begin
                check("defer_pending", pending, 1);
                check("defer_ready", cfg_ready, 0);
                check("defer_div_old", int'(div_cur), 4);
            end
            if (rc == 63) check("boundary_bit_tick", bit_tick, 1);
            if (rc == 64) begin
                check("applied_div", int'(div_cur), 6);
                check("applied_pending", pending, 0);
            end
            if (rc == 68) check("new_period_gap", s_tick, 0);
            if (rc == 69 || rc == 75) check("new_period_tick", s_tick, 1);
            step();
        end
        cfg_valid = 1'b0;
        check("first_s_tick_cycle", first_s, 3);
        check("first_bit_tick_cycle", first_b, 63);

        // Illegal divisor while running.
        cfg_div = 16'd1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("illegal_err", cfg_err, 1);
        check("illegal_div", int'(div_cur), 6);
        check("illegal_busy", busy, 1);
        check("illegal_pending", pending, 0);
        step();
        check("illegal_err_pulse", cfg_err, 0);

        // Reconfigure while idle, then run with the new divisor.
        en = 1'b0;
        step();
        check("idle_busy", busy, 0);
        cfg_div = 16'd8; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("idle_cfg_div", int'(div_cur), 8);
        check("idle_cfg_ready", cfg_ready, 1);
        en = 1'b1; cfg_div = 16'd6;
        step();
        first_s = -1; second_s = -1;
        for (int rc = 0; rc <= 30; rc++) begin
            cfg_valid = (rc == 10);
            if (s_tick) begin
                if (first_s < 0) first_s = rc;
                else if (second_s < 0) second_s = rc;
            end
            if (rc == 11) check("run8_pending", pending, 1);
            if (rc == 30) en = 1'b0;
            step();
        end
        cfg_valid = 1'b0;
        check("div8_first_s", first_s, 7);
        check("div8_second_s", second_s, 15);
        check("stop_busy", busy, 0);
        check("stop_pending", pending, 0);
        check("stop_div_applied", int'(div_cur), 6);
        check("stop_s_tick", s_tick, 0);
        en = 1'b1;
        step();
        first_s = -1;
        for (int rc = 0; rc < 12; rc++) begin
            if (s_tick && first_s < 0) first_s = rc;
            step();
        end
        check("restart_first_s", first_s, 5);

        // Reset in the middle of a pending change.
        cfg_div = 16'd10; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("pre_reset_pending", pending, 1);
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("async_rst_div", int'(div_cur), DEF);
        check("async_rst_pending", pending, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cfg_ready, 1);
        check("async_rst_s_tick", s_tick, 0);
        step();
        reset = 1'b0; en = 1'b0;
        step();
        check("post_rst_div", int'(div_cur), DEF);
        check("post_rst_pending", pending, 0);
        en = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
